move_sequencer: RTL
===================

# move_sequencer

Turn controller in front of `board_updater`. It accepts move requests from a black-side and a white-side source, and serves only the side to move. It pre-checks each move, pulses the updater, and waits for its verdict. On a legal verdict it commits the new board, maintains the ko board and the turn, and tracks passes and game-over.

## Interface
- `PASS_CODE`, default 8'hFF: move encoding meaning "pass".
- `TIMEOUT_CYCLES`, default 255: updater response limit in cycles. Used only with `MOVE_SEQ_TIMEOUT_EN`.

Ports:
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `new_game`  in  1  1-cycle pulse; clears the game.
- `req_b` / `req_w`  in  1 each  level request from the black / white source; held until acked or nacked.
- `move_b` / `move_w`  in  8 each  [7:4] row, [3:0] col, or `PASS_CODE`; stable while the request is high.
- `ack_b` / `ack_w`  out  1 each  1-cycle pulse: move committed.
- `nack_b` / `nack_w`  out  1 each  1-cycle pulse: move rejected.
- `upd_start`  out  1  1-cycle start pulse to the updater.
- `upd_move`  out  8  move to the updater.
- `upd_turn`  out  1  1 = white.
- `upd_board`  out  2×[8:0][8:0]  committed board, driven to the updater.
- `upd_ko`  out  2×[8:0][8:0]  ko board, driven to the updater.
- `upd_next_board`  in  2×[8:0][8:0]  updater result.
- `upd_valid` / `upd_invalid`  in  1 each  updater verdict pulses.
- `turn`  out  1  side to move; 0 = black.
- `move_count`  out  8  committed moves plus passes; saturates at 255.
- `game_over`  out  1  set after two consecutive passes.
- `err_timeout`  out  1  sticky updater-timeout flag.

## Operation
- States: IDLE, CHECK, START, WAIT, COMMIT, REJECT, OVER.
- **IDLE:** samples only the requester for `turn` (`req_b` if `turn`=0, else `req_w`). The other side's request stays pending with no ack or nack. The grant latches the move into `upd_move`, then goes to CHECK.
- **CHECK, pass:** the move equals `PASS_CODE`. Pass count increments, turn toggles, `move_count`++, ack, then IDLE. The second consecutive pass goes to OVER instead of IDLE.
- **CHECK, reject:** row>8 or col>8 (and not a pass), or the target square of `upd_board` is non-empty. Goes to REJECT; the updater is not invoked.
- **CHECK, otherwise:** goes to START.
- **START:** `upd_start`=1 for one cycle, then WAIT.
- **WAIT:** holds until `upd_valid` (COMMIT) or `upd_invalid` (REJECT).
- **COMMIT:** in one edge:
  - `upd_ko` ← old `upd_board`
  - `upd_board` ← `upd_next_board`, sampled on the edge where `upd_valid` is seen
  - `turn` toggles
  - pass count ← 0
  - `move_count`++
  - ack to the granted side
  - then IDLE.
- **REJECT:** nack to the granted side, then IDLE. Board, ko and turn are unchanged.
- **OVER:** `game_over`=1. Any request from either side is nacked one cycle after it is seen. Only `new_game` exits.
- **`new_game`:** clears board and ko to empty, `turn`=0, `move_count`=0, pass count=0, `game_over`=0, then IDLE.
  - In WAIT it is latched and applied after the updater verdict arrives; the verdict is discarded and no ack or nack is issued.
  - It does not clear `err_timeout`.
- Stray `upd_valid`/`upd_invalid` outside WAIT is ignored.
- `move_count` saturates at 255.

## Timing
- Reset values: all outputs 0, boards empty, state IDLE.
- Reset is asynchronous and valid mid-operation. The updater is reset separately by the system.
- Request seen at edge N: CHECK at N+1.
  - Pass: ack during cycle N+2.
  - Pre-check reject: nack during cycle N+3.
  - Otherwise: `upd_start` during cycle N+2.
- Verdict seen at edge M: ack or nack during cycle M+1. The source must drop `req` on the edge after its ack or nack, or it is re-sampled.
- Simultaneous `new_game` and grant in IDLE: `new_game` wins; the request stays pending and is served afterward.
- `upd_board`, `upd_ko`, `upd_turn` and `upd_move` are stable from START until the verdict.

## Configuration
- **`MOVE_SEQ_TIMEOUT_EN` defined:**
  - An 8+ bit counter runs in WAIT.
  - After `TIMEOUT_CYCLES` cycles with no verdict, go to REJECT and set `err_timeout`. It is sticky; only reset clears it.
  - A late verdict arriving in IDLE is ignored.
- **Not defined:** WAIT is unbounded, there is no counter, and `err_timeout` is tied to 0.

## Test plan
- **Legal move:** `turn`=0, `req_b` with 8'h44; stub updater answers valid 5 cycles after `upd_start` with center=2'b01. Expect one `ack_b`, `upd_board`[4][4]=01, `upd_ko`=empty, `turn`=1, `move_count`=1.
- **Wrong side, then out-of-range move:** `req_w` raised while `turn`=0 gets no ack or nack until black moves. Then `req_b` with 8'h9A gives `nack_b` with no `upd_start`.
- **Occupied target and updater invalid:** move onto an occupied square gives a nack with no `upd_start`. Updater answering invalid gives a nack; board, ko and `turn` are unchanged.
- **Passes:** `req_b` with 8'hFF then `req_w` with 8'hFF. Expect `game_over`=1 and `move_count`=2; a following `req_b` is nacked; `new_game` clears everything.
- **`new_game` in WAIT:** pulse `new_game` while waiting. The verdict is then discarded with no ack, and the board is empty afterward.
- **Timeout (with `MOVE_SEQ_TIMEOUT_EN`):** updater never answers. Expect a nack after `TIMEOUT_CYCLES`, `err_timeout`=1, and a late `upd_valid` ignored.

Source files
------------

// File: rtl/move_sequencer_if.sv
// ============================================================================
// Module      : move_sequencer_if
// Description : Bus between move_sequencer and board_updater.
//               master : sequencer side. It drives the start pulse, the move,
//                        the side to move, the committed board and the ko
//                        board. It receives the updater result and verdicts.
//               slave  : updater side, with the directions mirrored.
//               Boards are [row][col][cell]. Cell encoding: 00 empty,
//               01 black, 10 white.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface move_sequencer_if;
  logic                 upd_start;       // 1-cycle start pulse
  logic [7:0]           upd_move;        // [7:4] row, [3:0] col
  logic                 upd_turn;        // 1 = white
  logic [8:0][8:0][1:0] upd_board;       // committed board
  logic [8:0][8:0][1:0] upd_ko;          // previous committed board
  logic [8:0][8:0][1:0] upd_next_board;  // updater result
  logic                 upd_valid;       // verdict: legal
  logic                 upd_invalid;     // verdict: illegal

  modport master (
    output upd_start, upd_move, upd_turn, upd_board, upd_ko,
    input  upd_next_board, upd_valid, upd_invalid
  );

  modport slave (
    input  upd_start, upd_move, upd_turn, upd_board, upd_ko,
    output upd_next_board, upd_valid, upd_invalid
  );
endinterface

`default_nettype wire

// File: rtl/move_sequencer.sv
// ============================================================================
// Module      : move_sequencer
// Description : Turn controller in front of board_updater. It serves only the
//               side to move. It pre-checks the move for range and for an
//               occupied target, then runs the updater and waits for its
//               verdict. On a legal verdict it commits the board, the ko
//               board and the turn. It also tracks passes and game-over.
// Ports       : clk_in, rst_n_in   clock, async active-low reset
//               new_game           1-cycle clear pulse
//               req_b/w, move_b/w  level requests and their moves
//               ack_b/w, nack_b/w  1-cycle commit / reject pulses
//               upd                move_sequencer_if.master to the updater
//               turn               side to move (0 = black)
//               move_count         commits + passes, saturating at 255
//               game_over          two consecutive passes seen
//               err_timeout        sticky updater timeout
// Config      : define MOVE_SEQ_TIMEOUT_EN to bound the wait for a verdict
//               at TIMEOUT_CYCLES. When it is not defined, the wait is
//               unbounded and err_timeout is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_sequencer #(
  parameter logic [7:0]  PASS_CODE      = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  wire               clk_in,
  input  wire               rst_n_in,
  input  wire               new_game,
  input  wire               req_b,
  input  wire               req_w,
  input  wire  [7:0]        move_b,
  input  wire  [7:0]        move_w,
  output logic              ack_b,
  output logic              ack_w,
  output logic              nack_b,
  output logic              nack_w,
  move_sequencer_if.master  upd,
  output logic              turn,
  output logic [7:0]        move_count,
  output logic              game_over,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_COMMIT = 3'd4,
    S_REJECT = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("move_sequencer: TIMEOUT_CYCLES must be at least 1");
  end

  state_t               r_state;
  logic [8:0][8:0][1:0] r_board;
  logic [8:0][8:0][1:0] r_ko;
  logic                 r_turn;
  logic [7:0]           r_move;
  logic                 r_side;      // side that owns the current grant
  logic                 r_pass;      // previous action was a pass
  logic [7:0]           r_count;
  logic                 r_game_over;
  logic                 r_ng_pend;   // new_game seen while the updater runs
  logic                 r_start;
  logic                 r_ack_b;
  logic                 r_ack_w;
  logic                 r_nack_b;
  logic                 r_nack_w;

  logic       w_is_pass;
  logic       w_in_range;
  logic [3:0] w_row;
  logic [3:0] w_col;
  logic       w_occupied;
  logic       w_resp_busy;
  logic       w_grant_req;
  logic [7:0] w_grant_move;
  logic [7:0] w_count_inc;
  logic       w_verdict;
  logic       w_timeout;
  logic       w_wait_done;
  logic       w_clear_now;

  assign w_is_pass  = (r_move == PASS_CODE);
  assign w_in_range = (r_move[7:4] <= 4'd8) && (r_move[3:0] <= 4'd8);
  // Clamp the index so that an out-of-range move never addresses the board.
  assign w_row      = w_in_range ? r_move[7:4] : 4'd0;
  assign w_col      = w_in_range ? r_move[3:0] : 4'd0;
  assign w_occupied = w_in_range && (r_board[w_row][w_col] != 2'b00);

  // While an ack or nack is on the wire, the source still holds req.
  // Ignoring requests in that cycle prevents a double service.
  assign w_resp_busy  = r_ack_b | r_ack_w | r_nack_b | r_nack_w;
  assign w_grant_req  = r_turn ? req_w  : req_b;
  assign w_grant_move = r_turn ? move_w : move_b;
  assign w_count_inc  = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  assign w_verdict   = upd.upd_valid | upd.upd_invalid;
  assign w_wait_done = w_verdict | w_timeout;

`ifdef MOVE_SEQ_TIMEOUT_EN
  localparam int c_CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_err_timeout;

  assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == c_TO_LAST) && !w_verdict;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // A new_game in START or WAIT is deferred until the updater finishes.
  // In every other state it takes effect at once and wins over a grant.
  always_comb begin
    w_clear_now = 1'b0;
    case (r_state)
      S_START: w_clear_now = 1'b0;
      S_WAIT:  w_clear_now = (r_ng_pend | new_game) & w_wait_done;
      default: w_clear_now = new_game;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_board     <= '0;
      r_ko        <= '0;
      r_turn      <= 1'b0;
      r_move      <= 8'd0;
      r_side      <= 1'b0;
      r_pass      <= 1'b0;
      r_count     <= 8'd0;
      r_game_over <= 1'b0;
      r_ng_pend   <= 1'b0;
      r_start     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_ack_w     <= 1'b0;
      r_nack_b    <= 1'b0;
      r_nack_w    <= 1'b0;
    end else begin
      r_start  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_ack_w  <= 1'b0;
      r_nack_b <= 1'b0;
      r_nack_w <= 1'b0;

      if (w_clear_now) begin
        // Any verdict that arrives together with a deferred clear is dropped.
        r_board     <= '0;
        r_ko        <= '0;
        r_turn      <= 1'b0;
        r_count     <= 8'd0;
        r_pass      <= 1'b0;
        r_game_over <= 1'b0;
        r_ng_pend   <= 1'b0;
        r_state     <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_grant_req && !w_resp_busy) begin
              r_move  <= w_grant_move;
              r_side  <= r_turn;
              r_state <= S_CHECK;
            end
          end

          S_CHECK: begin
            if (w_is_pass) begin
              r_turn      <= ~r_turn;
              r_count     <= w_count_inc;
              r_pass      <= 1'b1;
              r_game_over <= r_pass;
              r_ack_b     <= ~r_side;
              r_ack_w     <= r_side;
              r_state     <= r_pass ? S_OVER : S_IDLE;
            end else if (!w_in_range || w_occupied) begin
              r_state <= S_REJECT;
            end else begin
              r_start <= 1'b1;
              r_state <= S_START;
            end
          end

          S_START: begin
            if (new_game) begin
              r_ng_pend <= 1'b1;
            end
            r_state <= S_WAIT;
          end

          S_WAIT: begin
            if (new_game) begin
              r_ng_pend <= 1'b1;
            end
            if (upd.upd_valid) begin
              r_ko    <= r_board;
              r_board <= upd.upd_next_board;
              r_turn  <= ~r_turn;
              r_pass  <= 1'b0;
              r_count <= w_count_inc;
              r_ack_b <= ~r_side;
              r_ack_w <= r_side;
              r_state <= S_COMMIT;
            end else if (upd.upd_invalid || w_timeout) begin
              r_nack_b <= ~r_side;
              r_nack_w <= r_side;
              r_state  <= S_REJECT;
            end
          end

          // The ack is already on the wire. This state only covers that cycle.
          S_COMMIT: r_state <= S_IDLE;

          // A verdict or timeout rejection raised its nack on the way in.
          // A pre-check rejection arrives with no nack yet and raises it here.
          S_REJECT: begin
            if (!(r_nack_b | r_nack_w)) begin
              r_nack_b <= ~r_side;
              r_nack_w <= r_side;
            end
            r_state <= S_IDLE;
          end

          S_OVER: begin
            if (!w_resp_busy) begin
              r_nack_b <= req_b;
              r_nack_w <= req_w;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ack_b      = r_ack_b;
  assign ack_w      = r_ack_w;
  assign nack_b     = r_nack_b;
  assign nack_w     = r_nack_w;
  assign turn       = r_turn;
  assign move_count = r_count;
  assign game_over  = r_game_over;

  assign upd.upd_start = r_start;
  assign upd.upd_move  = r_move;
  assign upd.upd_turn  = r_turn;
  assign upd.upd_board = r_board;
  assign upd.upd_ko    = r_ko;

endmodule

`default_nettype wire
